mem_wb_lsu: RTL and testbench
=============================

# mem_wb_lsu

Parametrised memory-and-writeback stage for the pipelined MIPS core. It replaces the fixed 32-bit M/W registers and the writeback-side load-byte selector, and supports:
- byte, halfword, word and (at XLEN=64) doubleword loads and stores, signed and unsigned;
- a req/ack memory handshake with wait states, which stalls the upstream pipeline;
- a bounded wait timeout, and misalignment detection.

It sits between the execute-stage ALU outputs and the register-file write port, and exports M-stage state to the hazard unit.

## Interface
- XLEN, 32: datapath width; legal values 32, 64.
- MAX_WAIT, 16: maximum cycles a memory request is held before abandonment; ≥1.

Ports:
- clk  in  1  clock
- reset  in  1  one clock; reset is synchronous and active-high
- aluoutE  in  XLEN  ALU result or effective address
- writedataE  in  XLEN  store data (already forwarded)
- writeregE  in  5  destination register
- regwriteE  in  1  instruction writes a register
- memenE  in  1  instruction is a load or store
- memopE  in  4  {store, size[1:0], unsigned}; size 00=B, 01=H, 10=W, 11=D
- stallM  out  1  hold E and earlier stages
- aluoutM, writeregM, regwriteM, memtoregM  out  XLEN/5/1/1  M-stage state for forwarding and hazards; memtoregM = memen & ~store
- mem_req  out  1  memory request valid
- mem_we  out  1  request is a store
- mem_addr  out  XLEN  address with the low log2(XLEN/8) bits cleared
- mem_be  out  XLEN/8  byte enables
- mem_wdata  out  XLEN  lane-replicated store data
- mem_rdata  in  XLEN  load data, valid when mem_ack=1
- mem_ack  in  1  request completes this cycle
- misalignM  out  1  one-cycle exception pulse
- berrM  out  1  one-cycle timeout pulse
- resultW, writeregW, regwriteW  out  XLEN/5/1  register-file write port

## Operation
- M register (aluout, writedata, writereg, regwrite, memen, memop) loads from the E inputs on every edge where stallM=0 and holds while stallM=1.
- Two-state FSM: IDLE, WAIT.
  - IDLE with a legal memory op in M: mem_req=1 combinationally.
    - mem_ack=1 in the same cycle: complete, no stall.
    - Otherwise: go to WAIT and assert stallM.
  - WAIT: mem_req=1 and stallM=1 until mem_ack.
    - On mem_ack: return to IDLE and drop stallM in that same cycle.
- Wait counter, width clog2(MAX_WAIT+1):
  - Counts cycles with mem_req=1 and mem_ack=0; clears on completion.
  - In the MAX_WAIT-th request cycle without ack: berrM=1, stallM=0, the op is abandoned, regwrite into W is suppressed, and the FSM returns to IDLE.
- Misalignment:
  - Conditions: H with addr[0]≠0; W with addr[1:0]≠0; D with addr[2:0]≠0; any D access when XLEN=32.
  - Effect: mem_req stays 0, misalignM=1 for one cycle, no stall, regwrite into W suppressed.
- Store encoding:
  - mem_be = size mask (B=1, H=3, W=0xF, D=0xFF) shifted left by the lane index, where lane = addr[log2(XLEN/8)-1:0].
  - mem_wdata = the low size bytes of writedata, replicated across the bus.
- Load extraction:
  - Shift mem_rdata right by lane×8 and take the low 8/16/32/64 bits.
  - Sign-extend when unsigned=0, zero-extend otherwise.
  - Extraction is performed in M at ack; the extracted value is registered into W.
- Non-memory ops: resultW = aluoutM, registered.
- W register: loads every edge.
  - While stallM=1 it loads a bubble (regwriteW=0).
  - Stores always give regwriteW=0.
- A late mem_ack arriving when no request is pending is ignored.

## Timing
- Reset values: all M/W registers 0, FSM IDLE, counter 0. Consequently stallM, mem_req, mem_we, mem_be, misalignM, berrM and regwriteW are all 0, and every data output is 0.
- A synchronous reset during WAIT clears M; mem_req and stallM fall after that edge.
- Latency:
  - ALU op: resultW valid 1 cycle after the op is in M.
  - Load with ack in cycle k of the request (k=1 is the first request cycle): resultW valid the cycle after the ack; stallM high for k−1 cycles.
- stallM and the misalignM/berrM pulses are combinational from M state and mem_ack. Hazard-unit logic must include stallM in its stallF/stallD terms.
- A misaligned op following a stalled load enters M only after the stall releases; at most one op is in M at a time.

## Test plan
- XLEN=32, lb at 0x1003, mem_rdata=0x80FF_1234, ack in first cycle -> mem_be=4'b1000, stallM never 1, next cycle resultW=0xFFFF_FF80, regwriteW=1.
- lhu at 0x2002, ack in the 4th request cycle, rdata=0xBEEF_0001 -> mem_be=4'b1100, stallM high 3 cycles, W bubbles during the stall, then resultW=0x0000_BEEF.
- sb at 0x13, writedata=0x1234_56AB -> mem_addr=0x10, mem_be=4'b1000, mem_wdata=0xABAB_ABAB, mem_we=1, regwriteW=0.
- lw at 0x1006 -> misalignM pulse of 1 cycle, mem_req=0, regwriteW=0; next instruction (addi result 0x5) -> resultW=0x5 one cycle later.
- MAX_WAIT=4, load never acked -> mem_req high 4 cycles, stallM high for the first 3, berrM=1 in the 4th, regwriteW=0; a late ack on the following cycle is ignored.
- XLEN=64, lwu at 0x...0C, rdata=0xFFFF_FFFF_0000_0000 -> mem_be=8'hF0, resultW=0x0000_0000_FFFF_FFFF; separately, reset asserted in the 2nd WAIT cycle -> mem_req and stallM are 0 after that edge.

Source files
------------

// File: rtl/mem_wb_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_lsu
// Description : Memory and writeback stage of the pipelined MIPS core.
//               Holds the M-stage register and drives a req/ack memory port
//               with byte/half/word/double stores and signed/unsigned loads.
//               Wait states stall upstream, a stuck request is abandoned
//               after MAX_WAIT cycles, and misaligned accesses are reported.
//               Feeds the registered W-stage register-file write port.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_lsu #(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [XLEN-1:0]     aluoutE,
    input  logic [XLEN-1:0]     writedataE,
    input  logic [4:0]          writeregE,
    input  logic                regwriteE,
    input  logic                memenE,
    input  logic [3:0]          memopE,
    output logic                stallM,
    output logic [XLEN-1:0]     aluoutM,
    output logic [4:0]          writeregM,
    output logic                regwriteM,
    output logic                memtoregM,
    output logic                mem_req,
    output logic                mem_we,
    output logic [XLEN-1:0]     mem_addr,
    output logic [XLEN/8-1:0]   mem_be,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic [XLEN-1:0]     mem_rdata,
    input  logic                mem_ack,
    output logic                misalignM,
    output logic                berrM,
    output logic [XLEN-1:0]     resultW,
    output logic [4:0]          writeregW,
    output logic                regwriteW
);

    localparam int NB = XLEN / 8;
    localparam int LW = $clog2(NB);
    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [XLEN-1:0]   aluout_q, wdata_q;
    logic [4:0]        wreg_q;
    logic              regwrite_q, memen_q;
    logic [3:0]        memop_q;

    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        wregw_q;
    logic              regwritew_q, regwritew_d;

    logic              is_store, is_unsigned;
    logic [1:0]        size;
    logic [LW-1:0]     lane;
    logic              misalign, req, timeout, stall;
    logic [NB-1:0]     be_mask;
    logic [XLEN-1:0]   wdata_rep, rshift, load_val;

    assign is_store    = memop_q[3];
    assign size        = memop_q[2:1];
    assign is_unsigned = memop_q[0];
    assign lane        = aluout_q[LW-1:0];

    // Alignment check: a double access can never be legal on a 32-bit bus.
    always_comb begin
        misalign = 1'b0;
        if (memen_q) begin
            case (size)
                2'b00:   misalign = 1'b0;
                2'b01:   misalign = aluout_q[0];
                2'b10:   misalign = (aluout_q[1:0] != 2'b00);
                default: misalign = (XLEN == 32) || (aluout_q[2:0] != 3'b000);
            endcase
        end
    end

    assign req     = memen_q & ~misalign;
    // The MAX_WAIT-th unacknowledged request cycle abandons the op instead of stalling.
    assign timeout = req & ~mem_ack & (cnt_q == CW'(MAX_WAIT - 1));
    assign stall   = req & ~mem_ack & ~timeout;

    // Request FSM and wait counter next-state; an ack with no request is ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = stall ? cnt_q + 1'b1 : '0;
        case (state_q)
            S_IDLE:  if (stall) state_d = S_WAIT;
            S_WAIT:  if (!stall) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request FSM and wait counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // M-stage register: holds its op while the memory port is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            aluout_q   <= '0;
            wdata_q    <= '0;
            wreg_q     <= '0;
            regwrite_q <= 1'b0;
            memen_q    <= 1'b0;
            memop_q    <= '0;
        end else if (!stall) begin
            aluout_q   <= aluoutE;
            wdata_q    <= writedataE;
            wreg_q     <= writeregE;
            regwrite_q <= regwriteE;
            memen_q    <= memenE;
            memop_q    <= memopE;
        end
    end

    // Store lane mask and lane-replicated store data.
    always_comb begin
        case (size)
            2'b00: begin
                be_mask   = NB'(1);
                wdata_rep = {NB{wdata_q[7:0]}};
            end
            2'b01: begin
                be_mask   = NB'(3);
                wdata_rep = {(NB/2){wdata_q[15:0]}};
            end
            2'b10: begin
                be_mask   = NB'(15);
                wdata_rep = {(NB/4){wdata_q[31:0]}};
            end
            default: begin
                be_mask   = '1;
                wdata_rep = wdata_q;
            end
        endcase
    end

    assign rshift = mem_rdata >> {lane, 3'b000};

    // Load extraction from the addressed lane with sign or zero extension.
    always_comb begin
        load_val = rshift;
        case (size)
            2'b00: begin
                if (is_unsigned) load_val = XLEN'(rshift[7:0]);
                else             load_val = XLEN'($signed(rshift[7:0]));
            end
            2'b01: begin
                if (is_unsigned) load_val = XLEN'(rshift[15:0]);
                else             load_val = XLEN'($signed(rshift[15:0]));
            end
            2'b10: begin
                if (is_unsigned) load_val = XLEN'(rshift[31:0]);
                else             load_val = XLEN'($signed(rshift[31:0]));
            end
            default: load_val = rshift;
        endcase
    end

    // W-stage next values: stalls, faults and stores all produce a non-writing slot.
    always_comb begin
        result_d    = (memen_q & ~is_store) ? load_val : aluout_q;
        regwritew_d = regwrite_q & ~stall & ~misalign & ~timeout & ~(memen_q & is_store);
    end

    // W-stage register loads on every edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q    <= '0;
            wregw_q     <= '0;
            regwritew_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            wregw_q     <= wreg_q;
            regwritew_q <= regwritew_d;
        end
    end

    assign stallM    = stall;
    assign aluoutM   = aluout_q;
    assign writeregM = wreg_q;
    assign regwriteM = regwrite_q;
    assign memtoregM = memen_q & ~is_store;
    assign mem_req   = req;
    assign mem_we    = req & is_store;
    assign mem_addr  = {aluout_q[XLEN-1:LW], LW'(0)};
    assign mem_be    = req ? (be_mask << lane) : '0;
    assign mem_wdata = wdata_rep;
    assign misalignM = misalign;
    assign berrM     = timeout;
    assign resultW   = result_q;
    assign writeregW = wregw_q;
    assign regwriteW = regwritew_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_lsu
// Description : Self-checking bench for mem_wb_lsu. Instance 0 is XLEN=32,
//               MAX_WAIT=4; instance 1 is XLEN=64, MAX_WAIT=16. A per-cycle
//               transaction model predicts every output; directed tests add
//               hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_lsu;

    logic clk;
    logic reset;

    logic [1:0][63:0] aluoutE_v, writedataE_v, mem_rdata_v;
    logic [1:0][4:0]  writeregE_v;
    logic [1:0][3:0]  memopE_v;
    logic [1:0]       regwriteE_v, memenE_v, mem_ack_v;

    wire  [1:0]       stallM_w, regwriteM_w, memtoregM_w, mem_req_w, mem_we_w;
    wire  [1:0]       misalignM_w, berrM_w, regwriteW_w;
    wire  [1:0][4:0]  writeregM_w, writeregW_w;

    wire  [31:0]      a0_aluoutM, a0_addr, a0_wdata, a0_resultW;
    wire  [3:0]       a0_be;
    wire  [63:0]      a1_aluoutM, a1_addr, a1_wdata, a1_resultW;
    wire  [7:0]       a1_be;

    int checks = 0;
    int errors = 0;

    // Model state per instance (state after the most recent clock edge).
    logic [63:0] mA [2];
    logic [63:0] mWD [2];
    logic [4:0]  mWR [2];
    logic        mRW [2];
    logic        mEN [2];
    logic [3:0]  mOP [2];
    int          mCnt [2];
    logic [63:0] wRes [2];
    logic [4:0]  wReg [2];
    logic        wRW [2];

    mem_wb_lsu #(.XLEN(32), .MAX_WAIT(4)) u0 (
        .clk(clk), .reset(reset),
        .aluoutE(aluoutE_v[0][31:0]), .writedataE(writedataE_v[0][31:0]),
        .writeregE(writeregE_v[0]), .regwriteE(regwriteE_v[0]),
        .memenE(memenE_v[0]), .memopE(memopE_v[0]),
        .stallM(stallM_w[0]), .aluoutM(a0_aluoutM), .writeregM(writeregM_w[0]),
        .regwriteM(regwriteM_w[0]), .memtoregM(memtoregM_w[0]),
        .mem_req(mem_req_w[0]), .mem_we(mem_we_w[0]), .mem_addr(a0_addr),
        .mem_be(a0_be), .mem_wdata(a0_wdata), .mem_rdata(mem_rdata_v[0][31:0]),
        .mem_ack(mem_ack_v[0]), .misalignM(misalignM_w[0]), .berrM(berrM_w[0]),
        .resultW(a0_resultW), .writeregW(writeregW_w[0]), .regwriteW(regwriteW_w[0])
    );

    mem_wb_lsu #(.XLEN(64), .MAX_WAIT(16)) u1 (
        .clk(clk), .reset(reset),
        .aluoutE(aluoutE_v[1]), .writedataE(writedataE_v[1]),
        .writeregE(writeregE_v[1]), .regwriteE(regwriteE_v[1]),
        .memenE(memenE_v[1]), .memopE(memopE_v[1]),
        .stallM(stallM_w[1]), .aluoutM(a1_aluoutM), .writeregM(writeregM_w[1]),
        .regwriteM(regwriteM_w[1]), .memtoregM(memtoregM_w[1]),
        .mem_req(mem_req_w[1]), .mem_we(mem_we_w[1]), .mem_addr(a1_addr),
        .mem_be(a1_be), .mem_wdata(a1_wdata), .mem_rdata(mem_rdata_v[1]),
        .mem_ack(mem_ack_v[1]), .misalignM(misalignM_w[1]), .berrM(berrM_w[1]),
        .resultW(a1_resultW), .writeregW(writeregW_w[1]), .regwriteW(regwriteW_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Predict the outputs of instance i from the op sitting in M, then advance.
    task automatic model_cycle(input int i);
        int          xlen, mw, nb, bytes, bits, lane;
        logic [63:0] xm, a, wd, sh, lmask, val, e_be, e_wdata, e_addr;
        logic [63:0] act_alu, act_addr, act_wdata, act_res, act_be;
        logic        st, un, en, mis, req, ack, tmo, stall;
        string       p;
        xlen  = (i == 0) ? 32 : 64;
        mw    = (i == 0) ? 4 : 16;
        nb    = xlen / 8;
        xm    = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        a     = mA[i];
        wd    = mWD[i];
        en    = mEN[i];
        st    = mOP[i][3];
        un    = mOP[i][0];
        bytes = 1 << mOP[i][2:1];
        bits  = bytes * 8;
        lane  = int'(a % 64'(nb));
        mis   = en && (((a % 64'(bytes)) != 64'd0) || (bytes > nb));
        ack   = mem_ack_v[i];
        req   = en && !mis;
        tmo   = req && !ack && (mCnt[i] == mw - 1);
        stall = req && !ack && !tmo;
        e_be  = req ? (((64'd1 << bytes) - 64'd1) << lane) : 64'd0;
        e_wdata = 64'd0;
        for (int k = 0; k < nb; k++)
            e_wdata = e_wdata | (((wd >> ((k % bytes) * 8)) & 64'hFF) << (k * 8));
        e_addr = a & ~64'(nb - 1);
        sh     = (mem_rdata_v[i] & xm) >> (lane * 8);
        lmask  = (bits >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
        val    = sh & lmask;
        if (!un && bits < 64 && val[bits-1]) val = val | ~lmask;
        val    = val & xm;

        act_alu   = (i == 0) ? {32'd0, a0_aluoutM} : a1_aluoutM;
        act_addr  = (i == 0) ? {32'd0, a0_addr}    : a1_addr;
        act_wdata = (i == 0) ? {32'd0, a0_wdata}   : a1_wdata;
        act_res   = (i == 0) ? {32'd0, a0_resultW} : a1_resultW;
        act_be    = (i == 0) ? {60'd0, a0_be}      : {56'd0, a1_be};
        p = $sformatf("u%0d.", i);

        chk({p, "stallM"},    64'(stallM_w[i]),    64'(stall));
        chk({p, "mem_req"},   64'(mem_req_w[i]),   64'(req));
        chk({p, "mem_we"},    64'(mem_we_w[i]),    64'(req && st));
        chk({p, "mem_be"},    act_be,              e_be);
        chk({p, "mem_addr"},  act_addr,            e_addr);
        chk({p, "mem_wdata"}, act_wdata,           e_wdata);
        chk({p, "misalignM"}, 64'(misalignM_w[i]), 64'(mis));
        chk({p, "berrM"},     64'(berrM_w[i]),     64'(tmo));
        chk({p, "aluoutM"},   act_alu,             a);
        chk({p, "writeregM"}, 64'(writeregM_w[i]), 64'(mWR[i]));
        chk({p, "regwriteM"}, 64'(regwriteM_w[i]), 64'(mRW[i]));
        chk({p, "memtoregM"}, 64'(memtoregM_w[i]), 64'(en && !st));
        chk({p, "regwriteW"}, 64'(regwriteW_w[i]), 64'(wRW[i]));
        chk({p, "writeregW"}, 64'(writeregW_w[i]), 64'(wReg[i]));
        if (wRW[i]) chk({p, "resultW"}, act_res, wRes[i]);

        if (reset) begin
            mA[i] = '0; mWD[i] = '0; mWR[i] = '0; mRW[i] = 1'b0; mEN[i] = 1'b0;
            mOP[i] = '0; mCnt[i] = 0; wRes[i] = '0; wReg[i] = '0; wRW[i] = 1'b0;
        end else begin
            wRW[i]  = mRW[i] && !stall && !mis && !tmo && !(en && st);
            wReg[i] = mWR[i];
            wRes[i] = (en && !st) ? val : a;
            mCnt[i] = stall ? mCnt[i] + 1 : 0;
            if (!stall) begin
                mA[i]  = aluoutE_v[i] & xm;
                mWD[i] = writedataE_v[i] & xm;
                mWR[i] = writeregE_v[i];
                mRW[i] = regwriteE_v[i];
                mEN[i] = memenE_v[i];
                mOP[i] = memopE_v[i];
            end
        end
    endtask

    // Compare process: outputs are checked on the falling edge, away from updates.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) model_cycle(i);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int i, input logic [3:0] op, input logic [63:0] a,
                         input logic [63:0] wd, input logic [4:0] wr, input logic rw,
                         input logic en);
        memenE_v[i] = en; memopE_v[i] = op; aluoutE_v[i] = a;
        writedataE_v[i] = wd; writeregE_v[i] = wr; regwriteE_v[i] = rw;
        cyc();
        memenE_v[i] = 1'b0; memopE_v[i] = '0; aluoutE_v[i] = '0;
        writedataE_v[i] = '0; writeregE_v[i] = '0; regwriteE_v[i] = 1'b0;
    endtask

    // Memory op acknowledged in request cycle k; W holds the outcome on return.
    task automatic mem_op(input int i, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] wd, input logic [63:0] rd, input int k,
                          input logic [4:0] wr, input logic rw);
        issue(i, op, a, wd, wr, rw, 1'b1);
        for (int c = 1; c <= k; c++) begin
            mem_ack_v[i] = (c == k);
            mem_rdata_v[i] = rd;
            cyc();
        end
        mem_ack_v[i] = 1'b0;
        mem_rdata_v[i] = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nst, nreq;
        reset = 1'b1;
        aluoutE_v = '0; writedataE_v = '0; mem_rdata_v = '0; writeregE_v = '0;
        memopE_v = '0; regwriteE_v = '0; memenE_v = '0; mem_ack_v = '0;
        for (int i = 0; i < 2; i++) begin
            mA[i] = '0; mWD[i] = '0; mWR[i] = '0; mRW[i] = 1'b0; mEN[i] = 1'b0;
            mOP[i] = '0; mCnt[i] = 0; wRes[i] = '0; wReg[i] = '0; wRW[i] = 1'b0;
        end
        cyc();
        cyc();
        // Reset state of both instances.
        chk("rst.stallM",    64'(stallM_w),    64'd0);
        chk("rst.mem_req",   64'(mem_req_w),   64'd0);
        chk("rst.regwriteW", 64'(regwriteW_w), 64'd0);
        chk("rst.berr_mis",  64'({berrM_w, misalignM_w}), 64'd0);
        chk("rst.u0.be",     64'(a0_be),       64'd0);
        chk("rst.u1.resultW", a1_resultW,      64'd0);
        reset = 1'b0;
        cyc();

        // lb at 0x1003, ack in the first request cycle.
        issue(0, 4'b0000, 64'h1003, 64'h0, 5'd5, 1'b1, 1'b1);
        mem_ack_v[0] = 1'b1; mem_rdata_v[0] = 64'h80FF_1234;
        #1;
        chk("lb.be",    64'(a0_be),       64'h8);
        chk("lb.stall", 64'(stallM_w[0]), 64'd0);
        cyc();
        mem_ack_v[0] = 1'b0; mem_rdata_v[0] = '0;
        chk("lb.resultW",   64'(a0_resultW),     64'hFFFF_FF80);
        chk("lb.regwriteW", 64'(regwriteW_w[0]), 64'd1);

        // lhu at 0x2002, ack in the 4th request cycle.
        issue(0, 4'b0011, 64'h2002, 64'h0, 5'd6, 1'b1, 1'b1);
        nst = 0;
        for (int k = 1; k <= 4; k++) begin
            mem_ack_v[0] = (k == 4);
            mem_rdata_v[0] = (k == 4) ? 64'hBEEF_0001 : 64'h0;
            #1;
            if (stallM_w[0]) nst++;
            if (k == 1) chk("lhu.be", 64'(a0_be), 64'hC);
            if (k == 3) chk("lhu.bubble", 64'(regwriteW_w[0]), 64'd0);
            cyc();
        end
        mem_ack_v[0] = 1'b0; mem_rdata_v[0] = '0;
        chk("lhu.stall_cycles", 64'(nst), 64'd3);
        chk("lhu.resultW", 64'(a0_resultW), 64'h0000_BEEF);
        chk("lhu.regwriteW", 64'(regwriteW_w[0]), 64'd1);

        // sb at 0x13.
        issue(0, 4'b1000, 64'h13, 64'h1234_56AB, 5'd7, 1'b1, 1'b1);
        mem_ack_v[0] = 1'b1;
        #1;
        chk("sb.addr",  64'(a0_addr),  64'h10);
        chk("sb.be",    64'(a0_be),    64'h8);
        chk("sb.wdata", 64'(a0_wdata), 64'hABAB_ABAB);
        chk("sb.we",    64'(mem_we_w[0]), 64'd1);
        cyc();
        mem_ack_v[0] = 1'b0;
        chk("sb.regwriteW", 64'(regwriteW_w[0]), 64'd0);

        // Misaligned lw at 0x1006 followed by an ALU op producing 5.
        issue(0, 4'b0100, 64'h1006, 64'h0, 5'd9, 1'b1, 1'b1);
        memenE_v[0] = 1'b0; aluoutE_v[0] = 64'h5; writeregE_v[0] = 5'd8; regwriteE_v[0] = 1'b1;
        #1;
        chk("lwmis.misalignM", 64'(misalignM_w[0]), 64'd1);
        chk("lwmis.mem_req",   64'(mem_req_w[0]),   64'd0);
        chk("lwmis.stall",     64'(stallM_w[0]),    64'd0);
        cyc();
        aluoutE_v[0] = '0; writeregE_v[0] = '0; regwriteE_v[0] = 1'b0;
        chk("lwmis.regwriteW", 64'(regwriteW_w[0]), 64'd0);
        chk("lwmis.pulse_end", 64'(misalignM_w[0]), 64'd0);
        cyc();
        chk("addi.resultW",   64'(a0_resultW),     64'h5);
        chk("addi.regwriteW", 64'(regwriteW_w[0]), 64'd1);

        // Load never acknowledged: abandoned in the 4th request cycle.
        issue(0, 4'b0100, 64'h100, 64'h0, 5'd10, 1'b1, 1'b1);
        nst = 0; nreq = 0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            if (stallM_w[0]) nst++;
            if (mem_req_w[0]) nreq++;
            if (k == 4) chk("tmo.berrM", 64'(berrM_w[0]), 64'd1);
            cyc();
        end
        chk("tmo.req_cycles",   64'(nreq), 64'd4);
        chk("tmo.stall_cycles", 64'(nst),  64'd3);
        chk("tmo.regwriteW",    64'(regwriteW_w[0]), 64'd0);
        mem_ack_v[0] = 1'b1; mem_rdata_v[0] = 64'h1234_5678;
        #1;
        chk("late_ack.req",  64'(mem_req_w[0]), 64'd0);
        chk("late_ack.berr", 64'(berrM_w[0]),   64'd0);
        cyc();
        mem_ack_v[0] = 1'b0; mem_rdata_v[0] = '0;
        chk("late_ack.regwriteW", 64'(regwriteW_w[0]), 64'd0);

        // Further 32-bit cases: double access, misaligned half, sh, lbu.
        issue(0, 4'b0110, 64'h1000, 64'h0, 5'd11, 1'b1, 1'b1);
        #1;
        chk("ld32.misalignM", 64'(misalignM_w[0]), 64'd1);
        cyc();
        mem_op(0, 4'b0010, 64'h1001, 64'h0, 64'h0, 1, 5'd12, 1'b1);
        mem_op(0, 4'b1010, 64'h2, 64'hCAFE, 64'h0, 2, 5'd0, 1'b0);
        mem_op(0, 4'b0001, 64'h1001, 64'h0, 64'h0000_8000, 1, 5'd13, 1'b1);
        chk("lbu.resultW", 64'(a0_resultW), 64'h80);

        // XLEN=64: lwu at 0x100C.
        issue(1, 4'b0101, 64'h100C, 64'h0, 5'd14, 1'b1, 1'b1);
        mem_ack_v[1] = 1'b1; mem_rdata_v[1] = 64'hFFFF_FFFF_0000_0000;
        #1;
        chk("lwu.be",   64'(a1_be), 64'hF0);
        chk("lwu.addr", a1_addr,    64'h1008);
        cyc();
        mem_ack_v[1] = 1'b0; mem_rdata_v[1] = '0;
        chk("lwu.resultW", a1_resultW, 64'h0000_0000_FFFF_FFFF);

        // Further 64-bit cases: ld, sd, sh, signed lb, misaligned ld.
        mem_op(1, 4'b0110, 64'h3010, 64'h0, 64'h8000_0000_0000_0001, 2, 5'd15, 1'b1);
        mem_op(1, 4'b1110, 64'h3008, 64'h1122_3344_5566_7788, 64'h0, 1, 5'd0, 1'b0);
        mem_op(1, 4'b1010, 64'h3006, 64'h0000_0000_0000_BEEF, 64'h0, 3, 5'd0, 1'b0);
        mem_op(1, 4'b0000, 64'h4005, 64'h0, 64'h0000_8000_0000_0000, 1, 5'd16, 1'b1);
        chk("lb64.resultW", a1_resultW, 64'hFFFF_FFFF_FFFF_FF80);
        mem_op(1, 4'b0110, 64'h3004, 64'h0, 64'h0, 1, 5'd17, 1'b1);

        // Synchronous reset during the second WAIT cycle.
        issue(1, 4'b0100, 64'h2000, 64'h0, 5'd18, 1'b1, 1'b1);
        #1;
        chk("rstw.stall_c1", 64'(stallM_w[1]), 64'd1);
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        chk("rstw.mem_req", 64'(mem_req_w[1]), 64'd0);
        chk("rstw.stallM",  64'(stallM_w[1]),  64'd0);
        issue(1, 4'b0000, 64'h7, 64'h0, 5'd19, 1'b1, 1'b0);
        cyc();
        chk("post_rst.resultW", a1_resultW, 64'h7);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
